// File: rtl/btn_pkg.sv
// Shared types and default timing for the user-button path.
// Cycle constants assume the 48 MHz system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG,
    REBOOT
  } btn_state_t;

  localparam int DEB_10MS     = 480000;
  localparam int LONG_2S      = 96000000;
  localparam int REBOOT_100US = 4800;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, polarity normalise and debounce filter.
// Output level is 1 while the button is pressed.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          pressed;

  assign pressed   = sync_q[1] ^ ACTIVE_LOW;
  assign btn_level = lvl_q;

  // any return to the current level restarts the stability window
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    if (pressed == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = pressed;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{ACTIVE_LOW}};
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// User-button decoder: press/release edges, short/long classification,
// LED toggle and a timed active-low reboot request.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEB_10MS,
  parameter int LONG_PRESS_CYCLES   = LONG_2S,
  parameter int REBOOT_PULSE_CYCLES = REBOOT_100US,
  parameter bit ACTIVE_LOW          = 1'b1
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic led_toggle,
  output logic reboot_n
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int RW = $clog2(REBOOT_PULSE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RW-1:0] RB_MAX   = RW'(REBOOT_PULSE_CYCLES - 1);

  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REBOOT_PULSE_CYCLES < 1) begin : g_bad_rb
    $error("REBOOT_PULSE_CYCLES must be >= 1");
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_deb (
    .clk      (clk48),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level)
  );

  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rb_q, rb_d;
  logic          prev_q;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          led_q, led_d;
  logic          reboot_n_q, reboot_n_d;
  logic          rise, fall;

  assign rise = btn_level & ~prev_q;
  assign fall = ~btn_level & prev_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rb_d       = rb_q;
    press_d    = rise;
    rel_d      = fall;
    short_d    = 1'b0;
    long_d     = 1'b0;
    led_d      = led_q;
    reboot_n_d = reboot_n_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          hold_d  = '0;
        end
      end
      // release is tested first so a same-cycle threshold stays short
      HELD: begin
        if (!btn_level) begin
          short_d = 1'b1;
          led_d   = ~led_q;
          state_d = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          long_d  = 1'b1;
          state_d = LONG;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_d    = REBOOT;
          rb_d       = '0;
          reboot_n_d = 1'b0;
        end
      end
      REBOOT: begin
        if (rb_q == RB_MAX) begin
          reboot_n_d = 1'b1;
          state_d    = IDLE;
        end else begin
          rb_d = rb_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rb_q       <= '0;
      prev_q     <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      led_q      <= 1'b0;
      reboot_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rb_q       <= rb_d;
      prev_q     <= btn_level;
      press_q    <= press_d;
      rel_q      <= rel_d;
      short_q    <= short_d;
      long_q     <= long_d;
      led_q      <= led_d;
      reboot_n_q <= reboot_n_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign led_toggle    = led_q;
  assign reboot_n      = reboot_n_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed phases plus random button
// activity, checked every cycle against a timestamp-based reference model.
module tb_button_event_decoder;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REB = 3;

  logic clk48 = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse;
  logic short_press, long_press, led_toggle, reboot_n;

  button_event_decoder #(
    .DEBOUNCE_CYCLES    (DEB),
    .LONG_PRESS_CYCLES  (LNG),
    .REBOOT_PULSE_CYCLES(REB),
    .ACTIVE_LOW         (1'b1)
  ) dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .led_toggle   (led_toggle),
    .reboot_n     (reboot_n)
  );

  always #5 clk48 = ~clk48;

  int errors = 0;
  int checks = 0;

  // model history, indexed by clock edge since reset release
  logic rawh [0:4095];
  logic lvlh [0:4095];
  int   n, last_chg, mode, s_t, e_t;
  logic m_pp, m_rp, m_sp, m_lp, m_led, m_reb;

  int seen_short, seen_long, seen_press, seen_rel, seen_low;

  function automatic logic raw_at(int k);
    return (k < 1) ? 1'b1 : rawh[k];
  endfunction

  function automatic logic lvl_at(int k);
    return (k < 1) ? 1'b0 : lvlh[k];
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    last_chg = 0;
    mode = 0;
    s_t = 0;
    e_t = 0;
    m_pp = 1'b0;
    m_rp = 1'b0;
    m_sp = 1'b0;
    m_lp = 1'b0;
    m_led = 1'b0;
    m_reb = 1'b1;
  endtask

  // level flips once the pressed sample (raw two edges back) has differed
  // from it for DEB consecutive edges since the last flip
  task automatic model_edge();
    logic cur, flip, a;
    n++;
    rawh[n] = btn_raw;
    cur = lvl_at(n - 1);
    flip = (n - DEB + 1 > last_chg);
    for (int k = n - DEB + 1; k <= n; k++)
      if (~raw_at(k - 2) == cur) flip = 1'b0;
    lvlh[n] = flip ? ~cur : cur;
    if (flip) last_chg = n;
    a = lvl_at(n - 1);
    m_pp = a & ~lvl_at(n - 2);
    m_rp = ~a & lvl_at(n - 2);
    m_sp = 1'b0;
    m_lp = 1'b0;
    case (mode)
      0: if (m_pp) begin mode = 1; s_t = n; end
      1: begin
        if (!a) begin
          m_sp = 1'b1;
          m_led = ~m_led;
          mode = 0;
        end else if (n - s_t == LNG) begin
          m_lp = 1'b1;
          mode = 2;
        end
      end
      2: if (!a) begin mode = 3; e_t = n; m_reb = 1'b0; end
      default: if (n - e_t == REB) begin m_reb = 1'b1; mode = 0; end
    endcase
  endtask

  task automatic check_all(string tag);
    chk({tag, ".btn_level"}, btn_level, lvl_at(n));
    chk({tag, ".press_pulse"}, press_pulse, m_pp);
    chk({tag, ".release_pulse"}, release_pulse, m_rp);
    chk({tag, ".short_press"}, short_press, m_sp);
    chk({tag, ".long_press"}, long_press, m_lp);
    chk({tag, ".led_toggle"}, led_toggle, m_led);
    chk({tag, ".reboot_n"}, reboot_n, m_reb);
  endtask

  task automatic check_reset(string tag);
    chk({tag, ".btn_level"}, btn_level, 1'b0);
    chk({tag, ".press_pulse"}, press_pulse, 1'b0);
    chk({tag, ".release_pulse"}, release_pulse, 1'b0);
    chk({tag, ".short_press"}, short_press, 1'b0);
    chk({tag, ".long_press"}, long_press, 1'b0);
    chk({tag, ".led_toggle"}, led_toggle, 1'b0);
    chk({tag, ".reboot_n"}, reboot_n, 1'b1);
  endtask

  task automatic clr_seen();
    seen_short = 0;
    seen_long = 0;
    seen_press = 0;
    seen_rel = 0;
    seen_low = 0;
  endtask

  task automatic tick(logic raw, string tag);
    btn_raw = raw;
    @(posedge clk48);
    model_edge();
    @(negedge clk48);
    check_all(tag);
    if (short_press) seen_short++;
    if (long_press) seen_long++;
    if (press_pulse) seen_press++;
    if (release_pulse) seen_rel++;
    if (!reboot_n) seen_low++;
  endtask

  initial begin
    int low_cnt;
    int total;
    int len;
    logic val;

    rst_n = 1'b0;
    btn_raw = 1'b1;
    model_reset();
    clr_seen();
    repeat (3) @(negedge clk48);
    check_reset("rst_hold");
    rst_n = 1'b1;
    repeat (10) tick(1'b1, "rst_idle");

    // clean short press
    clr_seen();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, "short_hold");
      if (i == 5) chk("short_lat_before", btn_level, 1'b0);
      if (i == 6) chk("short_lat_level", btn_level, 1'b1);
      if (i == 7) chk("short_press_pulse", press_pulse, 1'b1);
    end
    repeat (12) tick(1'b1, "short_rel");
    chk_int("short_count", seen_short, 1);
    chk_int("short_release_count", seen_rel, 1);
    chk_int("short_no_long", seen_long, 0);
    chk("short_led", led_toggle, 1'b1);

    // bounce shorter than the debounce window
    clr_seen();
    for (int i = 0; i < 20; i++)
      tick(((i / 2) % 2) == 0 ? 1'b0 : 1'b1, "bounce");
    repeat (10) tick(1'b1, "bounce_settle");
    chk_int("bounce_no_press", seen_press, 0);
    chk_int("bounce_no_short", seen_short, 0);
    chk("bounce_led", led_toggle, 1'b1);

    // long press then reboot pulse
    clr_seen();
    for (int i = 1; i <= 36; i++) begin
      tick(1'b0, "long_hold");
      if (i == 26) chk("long_not_yet", long_press, 1'b0);
      if (i == 27) chk("long_pulse", long_press, 1'b1);
    end
    repeat (20) tick(1'b1, "long_rel");
    chk_int("long_count", seen_long, 1);
    chk_int("long_no_short", seen_short, 0);
    chk_int("long_reboot_cycles", seen_low, REB);
    chk("long_led_kept", led_toggle, 1'b1);
    chk("long_reboot_done", reboot_n, 1'b1);

    // release lands on the threshold cycle: short wins
    clr_seen();
    repeat (20) tick(1'b0, "coll_hold");
    repeat (15) tick(1'b1, "coll_rel");
    chk_int("coll_short", seen_short, 1);
    chk_int("coll_no_long", seen_long, 0);
    chk_int("coll_no_reboot", seen_low, 0);
    chk("coll_led", led_toggle, 1'b0);

    // random runs of pressed/released levels
    total = 0;
    while (total < 450) begin
      len = $urandom_range(1, 40);
      val = 1'($urandom_range(0, 1));
      repeat (len) tick(val, "rand");
      total += len;
    end
    repeat (60) tick(1'b1, "rand_settle");

    // reset asserted in the 2nd low cycle of reboot_n, button held
    clr_seen();
    repeat (30) tick(1'b0, "mid_hold");
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, "mid_rel");
      if (!m_reb) low_cnt++;
      if (low_cnt == 2) break;
    end
    chk_int("mid_reboot_reached", low_cnt, 2);
    chk("mid_reboot_low", reboot_n, 1'b0);
    btn_raw = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk48);
    @(negedge clk48);
    check_reset("mid_rst_hold");
    rst_n = 1'b1;
    model_reset();
    clr_seen();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, "post_rst");
      if (i == 5) chk("post_rst_lvl_before", btn_level, 1'b0);
      if (i == 6) chk("post_rst_lvl", btn_level, 1'b1);
      if (i == 7) chk("post_rst_press", press_pulse, 1'b1);
    end
    repeat (30) tick(1'b0, "post_rst_hold");
    repeat (20) tick(1'b1, "post_rst_rel");
    chk_int("post_rst_long", seen_long, 1);
    chk_int("post_rst_reboot", seen_low, REB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
